// File: rtl/async_sample_sink_pkg.sv
// async_sink_pkg
// Shared types and constants for the async_sample_sink slice.
//   sink_state_t : handshake FSM states (IDLE waits for a request,
//                  ACK_HI holds the acknowledge until the request drops)
//   XFER_CNT_W   : width of the completed-capture counter
package async_sink_pkg;

  localparam int XFER_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } sink_state_t;

endpackage

// File: rtl/async_sample_sink_if.sv
// async_sample_sink_if
// Bundles the two handshakes that cross the sink boundary.
//   Ring side (4-phase bundled data):
//     req_in  - request from the self-timed ring, asynchronous to clk
//     data_in - bundled data word, stable while req_in is high
//     ack_out - registered acknowledge back to the ring
//   Stream side (valid/ready):
//     out_valid - a buffered word is available
//     out_ready - downstream takes out_data this cycle
//     out_data  - head word of the buffer
// Modports:
//   master - the environment (ring producer plus downstream consumer)
//   slave  - the sink itself
interface async_sample_sink_if #(
  parameter int WIDTH = 25
) ();

  logic             req_in;
  logic [WIDTH-1:0] data_in;
  logic             ack_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output req_in,
    output data_in,
    output out_ready,
    input  ack_out,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  req_in,
    input  data_in,
    input  out_ready,
    output ack_out,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/async_sample_sink_fifo.sv
// sink_fifo
// Small synchronous FIFO that buffers captured ring words.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset (empties the FIFO)
//   push       - write push_data (ignored while full)
//   push_data  - word to write
//   pop        - drop the head word (ignored while empty)
//   full       - no free entry; evaluated before any same-cycle pop
//   empty      - no stored word
//   head       - oldest stored word, read straight from the storage flops
// DEPTH must be a power of two >= 2.
module sink_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the
  // index bits are equal; the pointers wrap naturally.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/async_sample_sink.sv
// async_sample_sink
// Clocked consumer downstream of the self-timed adder ring. Synchronises
// the ring's 4-phase request, captures one data word per handshake into
// a FIFO, streams the words out on valid/ready and shows the low bits of
// the latest capture on the board display.
// Ports:
//   clk, rst_n   - only clock; asynchronous active-low reset
//   bus (slave)  - ring handshake (req_in/data_in/ack_out) and output
//                  stream (out_valid/out_ready/out_data)
//   display_pins - data_in[DISPLAY_WIDTH-1:0] of the most recent capture
//   xfer_count   - completed captures, wraps silently at 2^16
module async_sample_sink
  import async_sink_pkg::*;
#(
  parameter int WIDTH         = 25,
  parameter int DISPLAY_WIDTH = 8,
  parameter int DEPTH         = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  async_sample_sink_if.slave       bus,
  output logic [DISPLAY_WIDTH-1:0] display_pins,
  output logic [XFER_CNT_W-1:0]    xfer_count
);

  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     req_s;
  sink_state_t              state_q, state_d;
  logic                     ack_q, ack_d;
  logic [DISPLAY_WIDTH-1:0] display_q, display_d;
  logic [XFER_CNT_W-1:0]    xfer_count_q, xfer_count_d;
  logic                     fifo_push;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [WIDTH-1:0]         fifo_head;

  // Request synchroniser chain. Only req_in crosses through it; data_in
  // is bundled and is already stable by the time req_s is seen high.
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    if (i == 0) begin : g_first
      assign sync_d[i] = bus.req_in;
    end else begin : g_next
      assign sync_d[i] = sync_q[i-1];
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // A full FIFO keeps the FSM in IDLE with ack low, which stalls the
  // ring instead of dropping a word. The capture, display update, count
  // increment and ack rise all land on the same edge.
  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    display_d    = display_q;
    xfer_count_d = xfer_count_q;
    fifo_push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !fifo_full) begin
          fifo_push    = 1'b1;
          display_d    = bus.data_in[DISPLAY_WIDTH-1:0];
          xfer_count_d = xfer_count_q + XFER_CNT_W'(1);
          ack_d        = 1'b1;
          state_d      = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      ack_q        <= 1'b0;
      display_q    <= '0;
      xfer_count_q <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      ack_q        <= ack_d;
      display_q    <= display_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  sink_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus.data_in),
    .pop       (bus.out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign bus.ack_out   = ack_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign display_pins  = display_q;
  assign xfer_count    = xfer_count_q;

endmodule

// File: tb/tb_async_sample_sink.sv
// tb_async_sample_sink
// Scoreboard bench for async_sample_sink. A producer task plays the
// self-timed ring; every word it offers is pushed onto an expected queue
// and a separate monitor pops and compares whenever the stream hands a
// word over. Display and counter expectations come from a small model
// that simply counts offered words and remembers the last one.
module tb_async_sample_sink;

  localparam int W    = 25;
  localparam int DW   = 8;
  localparam int SYNC = 2;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] display_pins;
  logic [15:0]   xfer_count;

  async_sample_sink_if #(.WIDTH(W)) bus ();

  async_sample_sink #(
    .WIDTH         (W),
    .DISPLAY_WIDTH (DW),
    .DEPTH         (4),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .display_pins (display_pins),
    .xfer_count   (xfer_count)
  );

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  expQ[$];
  logic [15:0]   modelCount = 16'd0;
  logic [DW-1:0] modelDisplay = '0;
  int            readyMode = 0;
  logic [W-1:0]  expWord;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, required event never seen", name);
  endtask

  // Downstream ready: 0 = held low, 1 = held high, 2 = random per cycle.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 2) bus.out_ready = ($urandom_range(0, 1) == 1);
      else bus.out_ready = (readyMode == 1);
    end
  end

  // Monitor: every accepted stream word must be the oldest offered word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL stream word: actual %0h, required none", bus.out_data);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("stream word", bus.out_data, expWord);
      end
    end
  end

  task automatic waitAck(input logic value, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack_out !== value && n < 300);
    if (bus.ack_out !== value) reportTimeout(name);
  endtask

  task automatic waitDrain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.out_valid !== 1'b0 && n < 300);
    if (bus.out_valid !== 1'b0) reportTimeout("fifo drain");
  endtask

  task automatic offerWord(input logic [W-1:0] word);
    bus.req_in = 1'b1;
    expQ.push_back(word);
    modelCount   = modelCount + 16'd1;
    modelDisplay = word[DW-1:0];
  endtask

  // One complete 4-phase transfer as the ring would perform it.
  task automatic applyStimulus(input logic [W-1:0] word, input bit jitter);
    if (jitter) #($urandom_range(1, 23));
    else @(negedge clk);
    bus.data_in = word;
    if (jitter) #($urandom_range(0, 3));
    offerWord(word);
    waitAck(1'b1, "ack rise");
    if (jitter) #($urandom_range(1, 23));
    else @(negedge clk);
    bus.req_in = 1'b0;
    if (jitter) begin
      #1;
      bus.data_in = W'($urandom);
    end
    waitAck(1'b0, "ack fall");
  endtask

  task automatic pulseReady();
    @(negedge clk);
    readyMode = 1;
    @(negedge clk);
    readyMode = 0;
    @(negedge clk);
  endtask

  initial begin
    int edges;
    bit sawAck;

    rst_n       = 1'b0;
    bus.req_in  = 1'b0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset ack_out", bus.ack_out, 0);
    checkOutput("reset out_valid", bus.out_valid, 0);
    checkOutput("reset display_pins", display_pins, 0);
    checkOutput("reset xfer_count", xfer_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single transfer with deterministic request timing.
    $display("[TB] single transfer");
    bus.data_in = 25'h0000A5;
    offerWord(25'h0000A5);
    edges = 0;
    while (bus.ack_out !== 1'b1 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("ack rise latency", edges, SYNC + 1);
    checkOutput("single display_pins", display_pins, 8'hA5);
    checkOutput("single out_valid", bus.out_valid, 1);
    checkOutput("single out_data", bus.out_data, 25'h0000A5);
    checkOutput("single xfer_count", xfer_count, 1);
    bus.req_in = 1'b0;
    edges = 0;
    while (bus.ack_out !== 1'b0 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("ack fall latency", edges, SYNC + 1);
    pulseReady();
    checkOutput("single drained", bus.out_valid, 0);

    // Backpressure: fill the FIFO, the fifth request must stall.
    $display("[TB] backpressure");
    for (int i = 1; i <= 4; i++) applyStimulus(W'(i), 1'b0);
    @(negedge clk);
    bus.data_in = W'(5);
    offerWord(W'(5));
    sawAck = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack_out === 1'b1) sawAck = 1'b1;
    end
    checkOutput("no ack while full", sawAck, 0);
    checkOutput("count while stalled", xfer_count, 16'd5);
    checkOutput("head while full", bus.out_data, 1);
    pulseReady();
    waitAck(1'b1, "ack after pop");
    checkOutput("count after stall", xfer_count, modelCount);
    checkOutput("display after stall", display_pins, modelDisplay);
    @(negedge clk);
    bus.req_in = 1'b0;
    waitAck(1'b0, "ack fall after stall");
    readyMode = 1;
    waitDrain();
    readyMode = 0;

    // Push while popping: two words queued, ready goes high mid-transfer.
    $display("[TB] simultaneous push and pop");
    applyStimulus(W'($urandom), 1'b0);
    applyStimulus(W'($urandom), 1'b0);
    fork
      applyStimulus(W'($urandom), 1'b0);
      begin
        repeat (2) @(negedge clk);
        readyMode = 1;
      end
    join
    waitDrain();
    checkOutput("overlap queue empty", expQ.size(), 0);

    // Counter wrap: preload near the top instead of 65536 handshakes.
    $display("[TB] counter wrap");
    @(negedge clk);
    force dut.xfer_count_q = 16'hFFFD;
    @(negedge clk);
    release dut.xfer_count_q;
    modelCount = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(W'($urandom), 1'b0);
      checkOutput("wrap xfer_count", xfer_count, modelCount);
      checkOutput("wrap display_pins", display_pins, modelDisplay);
    end
    checkOutput("wrapped to zero", modelCount, xfer_count + 16'd0);
    waitDrain();

    // Reset in the middle of a handshake.
    $display("[TB] reset mid-handshake");
    readyMode = 0;
    @(negedge clk);
    bus.data_in = 25'h0000123;
    offerWord(25'h0000123);
    waitAck(1'b1, "ack before reset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset ack drops", bus.ack_out, 0);
    checkOutput("reset fifo empty", bus.out_valid, 0);
    checkOutput("reset count clear", xfer_count, 0);
    expQ.delete();
    modelCount   = 16'd0;
    modelDisplay = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    offerWord(25'h0000123);
    waitAck(1'b1, "recapture ack");
    checkOutput("recapture count", xfer_count, 1);
    checkOutput("recapture display", display_pins, 8'h23);
    @(negedge clk);
    bus.req_in = 1'b0;
    waitAck(1'b0, "recapture ack fall");
    readyMode = 1;
    waitDrain();
    checkOutput("single recapture", expQ.size(), 0);

    // Randomised producer timing and random downstream ready.
    $display("[TB] async jitter");
    readyMode = 2;
    for (int i = 0; i < 1000; i++) applyStimulus(W'($urandom), 1'b1);
    @(negedge clk);
    readyMode = 1;
    waitDrain();
    repeat (2) @(negedge clk);
    checkOutput("jitter queue empty", expQ.size(), 0);
    checkOutput("jitter xfer_count", xfer_count, modelCount);
    checkOutput("jitter display_pins", display_pins, modelDisplay);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
